edge_line_sequencer: RTL and testbench
======================================

# edge_line_sequencer

Line-level controller for the edge-detection datapath (smoothing filter → derivative → threshold compare). Accepts a pixel stream through a valid/ready handshake, drives the datapath's `enb` and 8-bit pixel input, and tracks each accepted pixel through the datapath's fixed latency with a tag shift register. Emits an aligned `edge_valid`/`edge_data` stream with end-of-line marking, flushes the pipeline with zero pixels after each line, and reports line completion.

## Interface
- `LINE_LEN`, 256: pixels per line (≥2); pixel counter width is clog2(LINE_LEN).
- `PIPE_LAT`, 3: number of `enb`-active clock edges from a pixel being sampled on `dp_in` until its result is stable on `dp_edges` (≥1).
- `clk`  in  1  single clock; all logic rising-edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `start`  in  1  begin one line; honoured only in IDLE.
- `pix_valid`  in  1  upstream pixel valid.
- `pix_data`  in  8  upstream pixel, uint8.
- `pix_ready`  out  1  controller accepts a pixel this cycle.
- `enb`  out  1  datapath enable.
- `dp_in`  out  8  pixel to the datapath input.
- `dp_edges`  in  8  datapath edge output.
- `edge_valid`  out  1  registered; `edge_data` is valid this cycle.
- `edge_data`  out  8  registered datapath result.
- `edge_last`  out  1  qualifies the final `edge_valid` of the line.
- `busy`  out  1  state ≠ IDLE.
- `line_done`  out  1  one-cycle pulse at line end.
- `edge_count`  out  16  non-zero results in the current line (see Configuration).

## Operation
- States: IDLE, STREAM, FLUSH, DONE.
  - IDLE → STREAM on `start`. Clears the pixel counter and `edge_count`.
  - STREAM → FLUSH on the transfer of pixel index LINE_LEN-1.
  - FLUSH → DONE after exactly PIPE_LAT cycles.
  - DONE → IDLE after one cycle.
- `start` outside IDLE is ignored.
- `pix_ready` = (state == STREAM). A transfer occurs when `pix_valid & pix_ready`.
- `enb` = transfer | (state == FLUSH). `dp_in` = `pix_data` on a transfer, otherwise 0x00.
  - `enb` stays low during IDLE, DONE and STREAM bubbles, so the datapath is frozen in those cycles.
- Tag shift register `tag[PIPE_LAT-1:0]` advances only when `enb` is high.
  - `tag[0]` loads 1 on a transfer and 0 on a flush cycle.
- `adv` is a register holding `enb` from the previous cycle.
- Every cycle: `edge_valid` ← `tag[PIPE_LAT-1] & adv`; `edge_data` ← `dp_edges` when that term is 1.
  - This guarantees exactly one `edge_valid` per accepted pixel, in order, with no duplicates across stalls.
- An output counter counts `edge_valid`. `edge_last` = `edge_valid` & (output count == LINE_LEN-1).
- `line_done` = (state == DONE). It coincides with `edge_last`.
- Reset mid-operation asynchronously returns the block to IDLE. Every register and output goes to 0, and all tags are dropped.

## Timing
- Reset values: `pix_ready`, `enb`, `dp_in`, `edge_valid`, `edge_data`, `edge_last`, `busy`, `line_done`, `edge_count` are all 0.
- `start` sampled in cycle S → STREAM (`pix_ready` = 1) in cycle S+1.
- With `enb` high continuously, a pixel transferred in cycle T gives `edge_valid` in cycle T+PIPE_LAT+1.
  - Each cycle of `enb` low in between adds one cycle.
- Last pixel transferred in cycle T:
  - FLUSH occupies T+1 … T+PIPE_LAT.
  - DONE, `line_done`, `edge_last` and the final `edge_valid` all occur in cycle T+PIPE_LAT+1.
  - IDLE in T+PIPE_LAT+2; the earliest next `start` is accepted there.
- No backpressure on the output side; the consumer must take every `edge_valid`.
- The first outputs of a line include smoothing contribution from the previous flush zeros. This is intended.

## Configuration
- `EDGE_COUNT_EN` defined:
  - A 16-bit counter increments on each `edge_valid` with `edge_data` ≠ 0 and saturates at 0xFFFF.
  - It is cleared on accepted `start` and by reset, and holds its value in IDLE until the next `start`.
- `EDGE_COUNT_EN` not defined: no counter logic; `edge_count` is tied to 0.

## Test plan
Benches use LINE_LEN=8, PIPE_LAT=3 and a 3-stage registered datapath model with `dp_edges` = in ^ 0xA5.
- Continuous line: `start`, then `pix_valid` = 1 with pixels 0..7 from cycle S+1. Required: 8 contiguous `edge_valid` in cycles S+5..S+12 with data 0xA5..0xA2; `edge_last` and `line_done` in S+12; `busy` low in S+13.
- Bubbles: `pix_valid` toggling 1/0 every cycle. Required: `enb` low on each 0 cycle; exactly 8 `edge_valid`, in order, no repeats; `edge_last` on the 8th.
- Illegal requests: `pix_valid` = 1 in IDLE gives `pix_ready` = 0 and `enb` = 0. `start` pulsed during STREAM gives no restart, and the pixel counter is unaffected.
- Reset mid-line: assert `reset` after the 5th transfer. Required: all outputs 0 immediately. A following `start` yields a clean 8-output line with no stale `edge_valid`.
- Back-to-back lines: `start` in the first IDLE cycle after DONE. Required: second line outputs begin 4 cycles after its first transfer; no loss or duplication.
- `EDGE_COUNT_EN`: datapath model returns non-zero for exactly 3 of 8 pixels. Required: `edge_count` = 3 at `line_done`, reset to 0 on the next `start`. Without the macro, `edge_count` = 0 throughout.

Source files
------------

// File: rtl/edge_line_sequencer.sv
// Line controller for the smoothing/derivative/threshold edge datapath: pixel handshake,
// latency tracking via enb-gated tags, flush and line completion. Define EDGE_COUNT_EN for edge_count.
module edge_line_sequencer #(
   parameter int LINE_LEN = 256,
   parameter int PIPE_LAT = 3
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        start_i,
   input  logic        pix_valid_i,
   input  logic [7:0]  pix_data_i,
   output logic        pix_ready_o,
   output logic        enb_o,
   output logic [7:0]  dp_in_o,
   input  logic [7:0]  dp_edges_i,
   output logic        edge_valid_o,
   output logic [7:0]  edge_data_o,
   output logic        edge_last_o,
   output logic        busy_o,
   output logic        line_done_o,
   output logic [15:0] edge_count_o
);
   localparam int CNT_W = $clog2(LINE_LEN);
   localparam int FL_W  = $clog2(PIPE_LAT + 1);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LINE_LEN - 1);
   localparam logic [FL_W-1:0]  FL_LAST  = FL_W'(PIPE_LAT - 1);

   typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    pix_cnt_q, pix_cnt_d;
   logic [CNT_W-1:0]    out_cnt_q, out_cnt_d;
   logic [FL_W-1:0]     fl_cnt_q, fl_cnt_d;
   logic [PIPE_LAT-1:0] tag_q, tag_d;
   logic                adv_q;
   logic                edge_valid_q, edge_last_q;
   logic [7:0]          edge_data_q;
   logic                xfer, enb, start_ok, ev_d;

   always_comb begin
      xfer      = pix_valid_i & (state_q == STREAM);
      enb       = xfer | (state_q == FLUSH);
      start_ok  = start_i & (state_q == IDLE);
      state_d   = state_q;
      pix_cnt_d = pix_cnt_q;
      fl_cnt_d  = fl_cnt_q;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d   = STREAM;
               pix_cnt_d = '0;
            end
         end
         STREAM: begin
            if (xfer) begin
               if (pix_cnt_q == LAST_IDX) begin
                  state_d  = FLUSH;
                  fl_cnt_d = '0;
               end else begin
                  pix_cnt_d = pix_cnt_q + 1'b1;
               end
            end
         end
         FLUSH: begin
            if (fl_cnt_q == FL_LAST) state_d = DONE;
            else                     fl_cnt_d = fl_cnt_q + 1'b1;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Tags only move when the datapath moves, so stalls never duplicate or drop a result.
      tag_d = tag_q;
      if (enb) begin
         tag_d    = tag_q << 1;
         tag_d[0] = xfer;
      end

      ev_d      = tag_q[PIPE_LAT-1] & adv_q;
      out_cnt_d = out_cnt_q;
      if (start_ok)  out_cnt_d = '0;
      else if (ev_d) out_cnt_d = out_cnt_q + 1'b1;
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q      <= IDLE;
         pix_cnt_q    <= '0;
         out_cnt_q    <= '0;
         fl_cnt_q     <= '0;
         tag_q        <= '0;
         adv_q        <= 1'b0;
         edge_valid_q <= 1'b0;
         edge_last_q  <= 1'b0;
         edge_data_q  <= '0;
      end else begin
         state_q      <= state_d;
         pix_cnt_q    <= pix_cnt_d;
         out_cnt_q    <= out_cnt_d;
         fl_cnt_q     <= fl_cnt_d;
         tag_q        <= tag_d;
         adv_q        <= enb;
         edge_valid_q <= ev_d;
         edge_last_q  <= ev_d & (out_cnt_q == LAST_IDX);
         if (ev_d) edge_data_q <= dp_edges_i;
      end
   end

`ifdef EDGE_COUNT_EN
   logic [15:0] ecnt_q, ecnt_d;

   always_comb begin
      ecnt_d = ecnt_q;
      if (start_ok)
         ecnt_d = '0;
      else if (ev_d && (dp_edges_i != 8'h00) && (ecnt_q != 16'hFFFF))
         ecnt_d = ecnt_q + 16'd1;
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) ecnt_q <= '0;
      else         ecnt_q <= ecnt_d;
   end

   assign edge_count_o = ecnt_q;
`else
   assign edge_count_o = 16'h0000;
`endif

   assign pix_ready_o  = (state_q == STREAM);
   assign enb_o        = enb;
   assign dp_in_o      = xfer ? pix_data_i : 8'h00;
   assign busy_o       = (state_q != IDLE);
   assign line_done_o  = (state_q == DONE);
   assign edge_valid_o = edge_valid_q;
   assign edge_data_o  = edge_data_q;
   assign edge_last_o  = edge_last_q;
endmodule

// File: tb/tb_edge_line_sequencer.sv
// Scoreboard bench for edge_line_sequencer with an enb-gated 3-register datapath (out = in ^ 0xA5).
module tb_edge_line_sequencer;
   localparam int LINE_LEN = 8;
   localparam int PIPE_LAT = 3;

   logic        clk_i = 1'b0;
   logic        reset_i, start_i, pix_valid_i;
   logic [7:0]  pix_data_i, dp_in_o, dp_edges_i, edge_data_o;
   logic        pix_ready_o, enb_o, edge_valid_o, edge_last_o, busy_o, line_done_o;
   logic [15:0] edge_count_o;

   always #5 clk_i = ~clk_i;

   edge_line_sequencer #(.LINE_LEN(LINE_LEN), .PIPE_LAT(PIPE_LAT)) dut (
      .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i),
      .pix_valid_i(pix_valid_i), .pix_data_i(pix_data_i), .pix_ready_o(pix_ready_o),
      .enb_o(enb_o), .dp_in_o(dp_in_o), .dp_edges_i(dp_edges_i),
      .edge_valid_o(edge_valid_o), .edge_data_o(edge_data_o), .edge_last_o(edge_last_o),
      .busy_o(busy_o), .line_done_o(line_done_o), .edge_count_o(edge_count_o)
   );

   logic [7:0] dp_r [PIPE_LAT];
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         for (int i = 0; i < PIPE_LAT; i++) dp_r[i] <= '0;
      end else if (enb_o) begin
         dp_r[0] <= dp_in_o;
         for (int i = 1; i < PIPE_LAT; i++) dp_r[i] <= dp_r[i-1];
      end
   end
   assign dp_edges_i = dp_r[PIPE_LAT-1] ^ 8'hA5;

   typedef struct {
      logic [7:0] data;
      logic       last;
      int         eidx;
   } exp_t;

   exp_t       exp_q[$];
   int         enb_cyc[$];
   int         cyc = 0;
   int         n_cmp = 0;
   int         n_fail = 0;
   logic [7:0] line_pix [LINE_LEN];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: each enb-active cycle is logged; a pixel whose enb index is n must appear
   // two cycles after the cycle holding enb index n+PIPE_LAT-1.
   initial begin : monitor
      exp_t e;
      int   exp_cnt, idx;
      logic clr_pend, prev_done;
      exp_cnt = 0; clr_pend = 1'b0; prev_done = 1'b0;
      forever begin
         @(negedge clk_i);
         cyc++;
         if (reset_i) begin
            exp_cnt = 0; clr_pend = 1'b0; prev_done = 1'b0;
         end else begin
            if (clr_pend) exp_cnt = 0;
            clr_pend = 1'b0;
            if (enb_o) enb_cyc.push_back(cyc);
            if (edge_valid_o) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_edge_valid", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  check("edge_data", edge_data_o, e.data);
                  check("edge_last", edge_last_o, e.last);
                  idx = e.eidx + PIPE_LAT - 1;
                  if (idx < enb_cyc.size()) check("latency_cycle", cyc, enb_cyc[idx] + 2);
                  else                      check("latency_enb_missing", 1, 0);
                  if (e.data != 8'h00 && exp_cnt != 65535) exp_cnt++;
`ifdef EDGE_COUNT_EN
                  check("edge_count", edge_count_o, exp_cnt);
`else
                  check("edge_count_tied", edge_count_o, 0);
`endif
               end
            end else if (edge_last_o) begin
               check("edge_last_without_valid", 1, 0);
            end
            if (line_done_o || edge_last_o) check("line_done_vs_edge_last", line_done_o, edge_last_o);
            if (prev_done) check("busy_after_done", busy_o, 0);
            prev_done = line_done_o;
            if (start_i && !busy_o) clr_pend = 1'b1;
         end
      end
   end

   // mode 0: continuous, 1: valid toggling, 2: random valid with stray start pulses
   task automatic run_line(input int mode, input int abort_after);
      int idx, guard;
      start_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      check("pix_ready_after_start", pix_ready_o, 1);
      check("edge_count_cleared", edge_count_o, 0);
      idx = 0; guard = 0;
      while (idx < LINE_LEN && guard < 200) begin
         case (mode)
            0:       pix_valid_i = 1'b1;
            1:       pix_valid_i = (guard % 2 == 0);
            default: pix_valid_i = ($urandom_range(0, 2) != 0);
         endcase
         pix_data_i = pix_valid_i ? line_pix[idx] : 8'($urandom);
         if (mode == 2) start_i = ($urandom_range(0, 3) == 0);
         #1;
         if (!pix_valid_i) begin
            check("enb_low_on_bubble", enb_o, 0);
            check("dp_in_zero_on_bubble", dp_in_o, 0);
         end
         if (pix_valid_i && pix_ready_o) begin
            exp_q.push_back('{data: line_pix[idx] ^ 8'hA5, last: (idx == LINE_LEN - 1),
                              eidx: enb_cyc.size()});
            idx++;
         end
         guard++;
         @(posedge clk_i); #1;
         if (idx == abort_after) begin
            reset_i = 1'b1;
            #1;
            check("rst_pix_ready", pix_ready_o, 0);
            check("rst_enb", enb_o, 0);
            check("rst_dp_in", dp_in_o, 0);
            check("rst_edge_valid", edge_valid_o, 0);
            check("rst_edge_last", edge_last_o, 0);
            check("rst_busy", busy_o, 0);
            check("rst_line_done", line_done_o, 0);
            check("rst_edge_count", edge_count_o, 0);
            exp_q.delete();
            pix_valid_i = 1'b0; start_i = 1'b0;
            repeat (2) @(posedge clk_i);
            #1 reset_i = 1'b0;
            return;
         end
      end
      if (idx < LINE_LEN) check("stream_timeout", idx, LINE_LEN);
      pix_valid_i = 1'b0; start_i = 1'b0;
      guard = 0;
      while (busy_o && guard < 40) begin
         @(posedge clk_i); #1;
         guard++;
      end
      if (busy_o) check("line_end_timeout", 1, 0);
   endtask

   task automatic fill_random();
      for (int i = 0; i < LINE_LEN; i++) line_pix[i] = 8'($urandom);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      int nz;
      reset_i = 1'b1; start_i = 1'b0; pix_valid_i = 1'b0; pix_data_i = 8'h00;
      repeat (2) @(posedge clk_i); #1;
      check("reset_pix_ready", pix_ready_o, 0);
      check("reset_enb", enb_o, 0);
      check("reset_dp_in", dp_in_o, 0);
      check("reset_edge_valid", edge_valid_o, 0);
      check("reset_edge_data", edge_data_o, 0);
      check("reset_edge_last", edge_last_o, 0);
      check("reset_busy", busy_o, 0);
      check("reset_line_done", line_done_o, 0);
      check("reset_edge_count", edge_count_o, 0);
      reset_i = 1'b0;
      @(posedge clk_i); #1;

      pix_valid_i = 1'b1; pix_data_i = 8'h3C;
      #1;
      check("idle_pix_ready", pix_ready_o, 0);
      check("idle_enb", enb_o, 0);
      check("idle_dp_in", dp_in_o, 0);
      @(posedge clk_i); #1;
      pix_valid_i = 1'b0;
      check("idle_stays_idle", busy_o, 0);

      for (int i = 0; i < LINE_LEN; i++) line_pix[i] = 8'(i);
      run_line(0, -1);
      fill_random();
      run_line(1, -1);
      fill_random();
      run_line(2, -1);

      fill_random();
      run_line(0, 5);
      @(posedge clk_i); #1;
      fill_random();
      run_line(0, -1);

      // Five pixels equal to 0xA5 map to zero results; three non-zero remain.
      nz = 0;
      for (int i = 0; i < LINE_LEN; i++) begin
         if ((i % 3) == 1 && nz < 3) begin
            line_pix[i] = 8'h10 + 8'(i);
            nz++;
         end else begin
            line_pix[i] = 8'hA5;
         end
      end
      run_line(1, -1);
      repeat (2) @(posedge clk_i); #1;
`ifdef EDGE_COUNT_EN
      check("edge_count_hold_idle", edge_count_o, 3);
`else
      check("edge_count_tied_idle", edge_count_o, 0);
`endif

      for (int l = 0; l < 6; l++) begin
         fill_random();
         run_line(l % 3, -1);
      end

      repeat (6) @(posedge clk_i); #1;
      check("scoreboard_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
